dtg: RTL and testbench
======================

DTG -- requirements
Module: dtg

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, horizontal sync width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.

REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clock, in, 1, 25 MHz pixel clock; one clock for the whole block.
- rst, in, 1, synchronous active-high reset.
- horiz_sync, out, 1, active-low horizontal sync.
- vert_sync, out, 1, active-low vertical sync.
- video_on, out, 1, high while the current position is visible.
- pixel_row, out, 10, current line (vertical count).
- pixel_column, out, 10, current pixel (horizontal count).
- frame_tick, out, 1, one-cycle pulse at the start of vertical blanking.

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default); frame = 420000 clocks.
REQ-004 pixel_column SHALL increment by 1 on every rising clock edge with rst low, and SHALL wrap from H_TOTAL-1 to 0.
REQ-005 pixel_row SHALL increment by 1 only on the edge where pixel_column wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-006 pixel_row and pixel_column SHALL be the counter registers themselves, with no combinational path from any input.
REQ-007 video_on SHALL be 1 when pixel_column < H_ACTIVE and pixel_row < V_ACTIVE, else 0.
REQ-008 horiz_sync SHALL be 0 when H_ACTIVE+H_FP <= pixel_column < H_ACTIVE+H_FP+H_SYNC (656..751 by default), else 1.
REQ-009 vert_sync SHALL be 0 when V_ACTIVE+V_FP <= pixel_row < V_ACTIVE+V_FP+V_SYNC (490..491 by default), else 1.
REQ-010 horiz_sync, vert_sync, video_on and frame_tick SHALL be registered, decoded from the next counter value, so that they align with pixel_row/pixel_column in the same cycle (subject to REQ-016).
REQ-011 frame_tick SHALL be 1 for exactly one cycle per frame, when pixel_row = V_ACTIVE and pixel_column = 0; it is 0 at all other positions.
REQ-012 Counter arithmetic SHALL be 10-bit unsigned, and a count SHALL never exceed its TOTAL-1.

Reset
REQ-013 On any edge with rst high, the following SHALL load on that edge, including mid-frame or mid-sync:
- pixel_row = 0, pixel_column = 0.
- video_on = 0, frame_tick = 0.
- horiz_sync = 1, vert_sync = 1.
REQ-014 On the first edge with rst low, position SHALL become (row 0, column 1) with video_on = 1; normal counting continues from there.
REQ-015 Reset held for N cycles SHALL hold every output at its reset value for all N cycles.

Configuration
REQ-016 Macro DTG_SYNC_DELAY_EN:
- Defined: horiz_sync, vert_sync and video_on SHALL lag pixel_row/pixel_column by exactly one additional clock through one extra register stage each. This aligns them with a one-cycle registered pixel lookup downstream. The extra registers take the REQ-013 reset values.
- Undefined: the alignment of REQ-010 holds.
- frame_tick is undelayed in both cases.

Verification
REQ-017 Release rst, then count 800 edges -> pixel_column sequence 1..799, 0; pixel_row steps 0 -> 1 on the wrap edge.
REQ-018 Run one full line -> horiz_sync = 0 for exactly 96 consecutive cycles, columns 656..751; video_on = 1 for columns 0..639 only.
REQ-019 Run a full frame -> vert_sync = 0 for rows 490..491 (1600 cycles); frame_tick is high once, at (480, 0); the next (0, 0) position occurs 420000 cycles after the previous one.
REQ-020 Assert rst for 3 cycles at (row 300, column 700, inside hsync) -> outputs hold 0/0/0/0/1/1 for 3 cycles; after release, the position is (0, 1) with horiz_sync = 1.
REQ-021 With DTG_SYNC_DELAY_EN defined -> horiz_sync falls one cycle after pixel_column = 656 and rises one cycle after 752; video_on falls when pixel_column = 641; frame_tick is unchanged versus the undefined build.

Source files
------------

// File: rtl/dtg.sv
// Display timing generator: free-running row/column counters with registered sync/blank decode.
// Build option DTG_SYNC_DELAY_EN delays horiz_sync, vert_sync and video_on by one extra clock.
module dtg #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clock,
    input  logic       rst,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       video_on,
    output logic [9:0] pixel_row,
    output logic [9:0] pixel_column,
    output logic       frame_tick
);
    localparam logic [9:0] H_TOTAL   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } sync_t;

    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, von: 1'b0};

    logic       col_wrap;
    logic [9:0] col_nxt;
    logic [9:0] row_nxt;
    logic       ft_nxt;
    sync_t      sync_nxt;
    sync_t      sync_q;

    // Decode from the next count so the registered flags line up with the counters.
    always_comb begin
        col_wrap = (pixel_column == H_TOTAL - 10'd1);
        col_nxt  = col_wrap ? 10'd0 : pixel_column + 10'd1;
        row_nxt  = pixel_row;
        if (col_wrap)
            row_nxt = (pixel_row == V_TOTAL - 10'd1) ? 10'd0 : pixel_row + 10'd1;
        sync_nxt.hs  = !((col_nxt >= H_SYNC_LO) && (col_nxt < H_SYNC_HI));
        sync_nxt.vs  = !((row_nxt >= V_SYNC_LO) && (row_nxt < V_SYNC_HI));
        sync_nxt.von = (col_nxt < H_ACT) && (row_nxt < V_ACT);
        ft_nxt       = (row_nxt == V_ACT) && (col_nxt == 10'd0);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            pixel_column <= '0;
            pixel_row    <= '0;
            sync_q       <= SYNC_RST;
            frame_tick   <= 1'b0;
        end else begin
            pixel_column <= col_nxt;
            pixel_row    <= row_nxt;
            sync_q       <= sync_nxt;
            frame_tick   <= ft_nxt;
        end
    end

`ifdef DTG_SYNC_DELAY_EN
    // Extra stage matches a one-cycle registered pixel fetch downstream.
    sync_t sync_d;

    always_ff @(posedge clock) begin
        if (rst) sync_d <= SYNC_RST;
        else     sync_d <= sync_q;
    end

    assign horiz_sync = sync_d.hs;
    assign vert_sync  = sync_d.vs;
    assign video_on   = sync_d.von;
`else
    assign horiz_sync = sync_q.hs;
    assign vert_sync  = sync_q.vs;
    assign video_on   = sync_q.von;
`endif

endmodule

// File: tb/tb_dtg.sv
// Bench for dtg: a default-size instance and a small-frame instance checked every cycle
// against a position-index model, plus directed line/frame/reset checks and random resets.
module tb_dtg;
    localparam int FR_D = 800 * 525;
    localparam int SH_A = 16, SH_FP = 4, SH_S = 6, SH_BP = 6;
    localparam int SV_A = 12, SV_FP = 2, SV_S = 2, SV_BP = 4;
    localparam int SH_T = SH_A + SH_FP + SH_S + SH_BP;
    localparam int FR_S = SH_T * (SV_A + SV_FP + SV_S + SV_BP);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
        logic [9:0] row;
        logic [9:0] col;
    } obs_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    logic       d_hs, d_vs, d_von, d_ft, s_hs, s_vs, s_von, s_ft;
    logic [9:0] d_row, d_col, s_row, s_col;

    dtg dut_d (
        .clock(clock), .rst(rst), .horiz_sync(d_hs), .vert_sync(d_vs), .video_on(d_von),
        .pixel_row(d_row), .pixel_column(d_col), .frame_tick(d_ft)
    );

    dtg #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
    ) dut_s (
        .clock(clock), .rst(rst), .horiz_sync(s_hs), .vert_sync(s_vs), .video_on(s_von),
        .pixel_row(s_row), .pixel_column(s_col), .frame_tick(s_ft)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   pd = 0;
    int   ps = 0;
    obs_t prev_d, prev_s;

    // Outputs as a pure function of the position index p = row*H_TOTAL + col.
    function automatic obs_t model(int p, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, bit r);
        obs_t o;
        int   ht, row, col;
        ht  = ha + hf + hsw + hb;
        row = p / ht;
        col = p % ht;
        o.row = 10'(row);
        o.col = 10'(col);
        o.von = (col < ha) && (row < va);
        o.hs  = !((col >= ha + hf) && (col < ha + hf + hsw));
        o.vs  = !((row >= va + vf) && (row < va + vf + vsw));
        o.ft  = (row == va) && (col == 0);
        if (r) o = '{hs: 1'b1, vs: 1'b1, von: 1'b0, ft: 1'b0, row: 10'd0, col: 10'd0};
        return o;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            if (n_fail <= 40)
                $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: advance the model with the rst value seen at the edge, then compare.
    task automatic step();
        bit   r;
        obs_t ud, us, ed, es;
        @(posedge clock);
        r = rst;
        #1;
        cyc++;
        if (r) begin
            pd = 0;
            ps = 0;
        end else begin
            pd = (pd + 1) % FR_D;
            ps = (ps + 1) % FR_S;
        end
        ud = model(pd, 640, 16, 96, 48, 480, 10, 2, r);
        us = model(ps, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, r);
        ed = ud;
        es = us;
`ifdef DTG_SYNC_DELAY_EN
        if (!r) begin
            {ed.hs, ed.vs, ed.von} = {prev_d.hs, prev_d.vs, prev_d.von};
            {es.hs, es.vs, es.von} = {prev_s.hs, prev_s.vs, prev_s.von};
        end
`endif
        prev_d = ud;
        prev_s = us;
        chk("model_default", 32'({d_hs, d_vs, d_von, d_ft, d_row, d_col}), 32'(ed));
        chk("model_small",   32'({s_hs, s_vs, s_von, s_ft, s_row, s_col}), 32'(es));
    endtask

    initial begin
        int von_cnt, hs_cnt, run, max_run, first_col, ft_cnt, vs_cnt, last00;
        int exp_first;

        // Reset held: reset values every cycle (checked inside step).
        rst = 1'b1;
        repeat (3) step();
        chk("rst_col", 32'(d_col), 32'd0);
        chk("rst_hs", 32'(d_hs), 32'd1);

        // Release and run one line.
        rst = 1'b0;
        step();
        chk("rel_row", 32'(d_row), 32'd0);
        chk("rel_col", 32'(d_col), 32'd1);
        repeat (799) step();
        chk("wrap_col", 32'(d_col), 32'd0);
        chk("wrap_row", 32'(d_row), 32'd1);

        // Full line scan: hsync width/position, visible width.
        von_cnt = 0; hs_cnt = 0; run = 0; max_run = 0; first_col = -1;
        repeat (800) begin
            step();
            if (d_von) von_cnt++;
            if (!d_hs) begin
                if (run == 0 && first_col < 0) first_col = int'(d_col);
                hs_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else run = 0;
        end
`ifdef DTG_SYNC_DELAY_EN
        exp_first = 657;
`else
        exp_first = 656;
`endif
        chk("line_von_cnt", 32'(von_cnt), 32'd640);
        chk("line_hs_cnt", 32'(hs_cnt), 32'd96);
        chk("line_hs_run", 32'(max_run), 32'd96);
        chk("line_hs_first", 32'(first_col), 32'(exp_first));

        // Reset inside hsync, held 3 cycles.
        repeat (700) step();
        chk("pre_rst_col", 32'(d_col), 32'd700);
        chk("pre_rst_hs", 32'(d_hs), 32'd0);
        rst = 1'b1;
        repeat (3) begin
            step();
            chk("hold_rst", 32'({d_row, d_col, d_von, d_ft, d_hs, d_vs}), 32'({20'd0, 4'b0011}));
        end
        rst = 1'b0;
        step();
        chk("post_rst_pos", 32'({d_row, d_col}), 32'({10'd0, 10'd1}));
        chk("post_rst_hs", 32'(d_hs), 32'd1);

        // Three frames of the small instance.
        ft_cnt = 0; vs_cnt = 0; last00 = -1;
        repeat (3 * FR_S) begin
            step();
            if (s_ft) begin
                ft_cnt++;
                chk("ft_pos", 32'({s_row, s_col}), 32'({10'(SV_A), 10'd0}));
            end
            if (!s_vs) vs_cnt++;
            if (s_row == 10'd0 && s_col == 10'd0) begin
                if (last00 >= 0) chk("frame_period", 32'(cyc - last00), 32'(FR_S));
                last00 = cyc;
            end
        end
        chk("ft_count", 32'(ft_cnt), 32'd3);
        chk("vs_count", 32'(vs_cnt), 32'(3 * SV_S * SH_T));

        // Random run lengths with random reset pulses.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(1, 300)) step();
            rst = 1'b1;
            repeat ($urandom_range(1, 4)) step();
            rst = 1'b0;
        end
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
